// File: rtl/if_predict_stage.sv
// IF-stage fetch/predict unit: holds the PC, predicts the next fetch address from the
// 2-bit branch buffer (B-type) or always-taken (JAL), and registers the fetch into IF/ID.
module if_predict_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IDX_W    = 4,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Stall,
    input  logic             Redirect,
    input  logic [31:0]      RedirectPC,
    output logic [31:0]      InstAddr,
    input  logic [31:0]      InstData,
    output logic [IDX_W-1:0] ReadNum,
    input  logic [1:0]       current_state,
    output logic [31:0]      PC_ID,
    output logic [31:0]      Inst_ID,
    output logic             PredTaken_ID,
    output logic [1:0]       current_state_ID,
    output logic [IDX_W-1:0] WriteNum_ID,
    output logic             Valid_ID
);

    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [1:0] STATE_RESET = 2'b01;

    logic [31:0]      r_pc;
    logic [31:0]      r_pc_id;
    logic [31:0]      r_inst_id;
    logic             r_pred_taken_id;
    logic [1:0]       r_state_id;
    logic [IDX_W-1:0] r_write_num_id;
    logic             r_valid_id;

    logic [6:0]       w_opcode;
    logic             w_is_branch;
    logic             w_is_jal;
    logic [31:0]      w_imm_b;
    logic [31:0]      w_imm_j;
    logic [31:0]      w_imm;
    logic             w_taken;
    logic [31:0]      w_next_pc;
    logic [IDX_W-1:0] w_read_num;

    // Fetch address and buffer index are direct views of the PC, with no register stage.
    assign w_read_num = r_pc[IDX_W+1:2];
    assign InstAddr   = r_pc;
    assign ReadNum    = w_read_num;

    assign w_opcode    = InstData[6:0];
    assign w_is_branch = (w_opcode == OPC_BRANCH);
    assign w_is_jal    = (w_opcode == OPC_JAL);

    assign w_imm_b = {{20{InstData[31]}}, InstData[7], InstData[30:25], InstData[11:8], 1'b0};
    assign w_imm_j = {{12{InstData[31]}}, InstData[19:12], InstData[20], InstData[30:21], 1'b0};

    // JALR is deliberately not predicted; ID corrects it through Redirect.
    always_comb begin
        w_imm   = w_imm_b;
        w_taken = 1'b0;
        if (w_is_jal) begin
            w_imm   = w_imm_j;
            w_taken = 1'b1;
        end else if (w_is_branch) begin
            w_imm   = w_imm_b;
            w_taken = current_state[1];
        end
    end

    assign w_next_pc = w_taken ? (r_pc + w_imm) : (r_pc + 32'd4);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_pc <= RESET_PC;
        end else if (Redirect) begin
            r_pc <= RedirectPC;
        end else if (!Stall) begin
            r_pc <= w_next_pc;
        end
    end

    // A redirect squashes the wrong-path fetch even when ID is also asking for a stall.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_pc_id         <= 32'd0;
            r_inst_id       <= NOP_INST;
            r_pred_taken_id <= 1'b0;
            r_state_id      <= STATE_RESET;
            r_write_num_id  <= '0;
            r_valid_id      <= 1'b0;
        end else if (Redirect) begin
            r_pc_id         <= 32'd0;
            r_inst_id       <= NOP_INST;
            r_pred_taken_id <= 1'b0;
            r_state_id      <= STATE_RESET;
            r_write_num_id  <= '0;
            r_valid_id      <= 1'b0;
        end else if (!Stall) begin
            r_pc_id         <= r_pc;
            r_inst_id       <= InstData;
            r_pred_taken_id <= w_taken;
            r_state_id      <= current_state;
            r_write_num_id  <= w_read_num;
            r_valid_id      <= 1'b1;
        end
    end

    assign PC_ID            = r_pc_id;
    assign Inst_ID          = r_inst_id;
    assign PredTaken_ID     = r_pred_taken_id;
    assign current_state_ID = r_state_id;
    assign WriteNum_ID      = r_write_num_id;
    assign Valid_ID         = r_valid_id;

endmodule
